approx_mult16_sequencer: RTL
============================

Name: approx_mult16_sequencer

Overview:
- Iterative 16x16 unsigned multiplier controller built around one shared 8x8 approximate multiplier instance (underdesigned_multiplier8, combinational, instantiated outside this block).
- Splits each operand into 8-bit halves and issues the four partial products through the shared multiplier, one per cycle.
- Accumulates the shifted partial products into a 32-bit result.
- Valid/ready handshakes on the input and output sides. Sits between a requester and the multiplier datapath.

Parameters:
TRUNC_LL, 0, when 1 the low×low partial product is skipped: 3 issue cycles instead of 4, extra approximation.

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  operands valid
in_ready_o  output  1  block can accept operands
op1_i  input  16  multiplicand
op2_i  input  16  multiplier
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
product_o  output  32  accumulated product
busy_o  output  1  high in MUL or DONE
mul_op1_o  output  8  operand A to shared 8x8 multiplier
mul_op2_o  output  8  operand B to shared 8x8 multiplier
mul_product_i  input  16  combinational product from shared multiplier

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; idx=0; accumulator=0; operand registers=0.
  - in_ready_o=1 after release; out_valid_o=0; busy_o=0; product_o=0; mul_op1_o=mul_op2_o=0.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&in_ready_o: latch op1_i/op2_i into a_q/b_q, clear accumulator, idx=(TRUNC_LL?1:0), go MUL.
  - mul_op*_o=0 in IDLE.
- MUL (in_ready_o=0, busy_o=1):
  - mul_op1_o/mul_op2_o are driven combinationally from a_q/b_q halves selected by idx:
    - idx0: A_L×B_L, shift 0.
    - idx1: A_L×B_H, shift 8.
    - idx2: A_H×B_L, shift 8.
    - idx3: A_H×B_H, shift 16.
  - At each clock edge: acc <= acc + (zero-extend(mul_product_i) << shift), modulo 2^32.
  - idx increments. After the idx3 edge, go DONE.
- DONE:
  - out_valid_o=1; product_o=acc, held stable.
  - in_ready_o=0; mul_op*_o=0.
  - On out_valid_o&out_ready_i: go IDLE, out_valid_o=0 next cycle. product_o holds its last value until the next accept clears acc.
- Latency:
  - TRUNC_LL=0: accept edge at cycle 0, out_valid_o high from cycle 5 (4 issue cycles).
  - TRUNC_LL=1: out_valid_o high from cycle 4.
  - Throughput: one operation per (issue cycles + 2) cycles when out_ready_i is held high. No overlap between consecutive operations.
- Boundaries:
  - in_valid_i while busy: ignored (in_ready_o=0), operands not sampled.
  - out_ready_i held low: stay in DONE indefinitely, output stable.
  - out_ready_i high before DONE: no effect.
  - Zero operands: the full sequence still runs, result 0.
  - Reset asserted mid-MUL or in DONE: immediate abort to the reset state. The partial result is discarded and no out_valid_o is produced.
- Accumulator width: 32 bits is sufficient. The approximate products never exceed the exact products, so no overflow occurs in practice; the wrap is defined anyway.

Test Plan:
- Exact-model stub (mul_product_i = a*b), TRUNC_LL=0: op1=0x1234, op2=0x5678, out_ready_i=1 -> out_valid_o at cycle 5, product_o=0x06260060, single-cycle pulse, in_ready_o back high at cycle 6.
- Real underdesigned_multiplier8, TRUNC_LL=0: 0xFFFF×0xFFFF -> product_o=0xC71AE38F (the 8x8 approximate product 0xFF×0xFF is 0xC58F).
- Exact stub, TRUNC_LL=1: 0x00FF×0x00FF -> product_o=0x00000000 at cycle 4; 0x0100×0x0100 -> 0x00010000.
- Back-pressure: out_ready_i=0 for 10 cycles after DONE -> out_valid_o and product_o stable, in_ready_o=0 throughout. Raise out_ready_i -> handshake, IDLE next cycle. in_valid_i pulses during MUL are ignored.
- Reset mid-operation: assert rst_ni=0 at cycle 2 of MUL -> all outputs immediately 0/reset values. After release, a new request 0x0002×0x0003 -> product_o=0x00000006 with normal latency.

Source files
------------

// File: rtl/approx_mult16_sequencer.sv
// Iterative 16x16 unsigned multiplier controller. Splits each operand into
// 8-bit halves, issues the partial products one per cycle through a shared
// external 8x8 (approximate) multiplier and accumulates them into 32 bits.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   in_valid_i / in_ready_o  operand handshake (op1_i, op2_i)
//   out_valid_o / out_ready_i result handshake (product_o)
//   busy_o                   high while multiplying or holding a result
//   mul_op1_o, mul_op2_o     operands to the shared 8x8 multiplier (combinational)
//   mul_product_i            combinational product from the shared multiplier
module approx_mult16_sequencer #(
  parameter bit TRUNC_LL = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] op1_i,
  input  logic [15:0] op2_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] product_o,
  output logic        busy_o,
  output logic [7:0]  mul_op1_o,
  output logic [7:0]  mul_op2_o,
  input  logic [15:0] mul_product_i
);

  localparam int unsigned OP_W   = 16;
  localparam int unsigned HALF_W = 8;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [PROD_W-1:0]   acc_q;
  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [HALF_W-1:0]   sel_a;
  logic [HALF_W-1:0]   sel_b;
  logic [PROD_W-1:0]   part_shifted;

  // Partial-product selection and alignment for the current issue index.
  always_comb begin
    sel_a        = '0;
    sel_b        = '0;
    part_shifted = '0;
    case (idx_q)
      2'd0: begin
        sel_a        = a_q[HALF_W-1:0];
        sel_b        = b_q[HALF_W-1:0];
        part_shifted = PROD_W'(mul_product_i);
      end
      2'd1: begin
        sel_a        = a_q[HALF_W-1:0];
        sel_b        = b_q[OP_W-1:HALF_W];
        part_shifted = PROD_W'(mul_product_i) << HALF_W;
      end
      2'd2: begin
        sel_a        = a_q[OP_W-1:HALF_W];
        sel_b        = b_q[HALF_W-1:0];
        part_shifted = PROD_W'(mul_product_i) << HALF_W;
      end
      default: begin
        sel_a        = a_q[OP_W-1:HALF_W];
        sel_b        = b_q[OP_W-1:HALF_W];
        part_shifted = PROD_W'(mul_product_i) << (2 * HALF_W);
      end
    endcase
  end

  // Shared multiplier sees zeros outside the issue phase.
  assign mul_op1_o = (state_q == ST_MUL) ? sel_a : '0;
  assign mul_op2_o = (state_q == ST_MUL) ? sel_b : '0;

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i && in_ready_q) begin
            a_q        <= op1_i;
            b_q        <= op2_i;
            acc_q      <= '0;
            // Truncated mode skips the low x low partial product.
            idx_q      <= TRUNC_LL ? IDX_W'(1) : IDX_W'(0);
            state_q    <= ST_MUL;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_MUL: begin
          acc_q <= acc_q + part_shifted;
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(3)) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign product_o   = acc_q;

endmodule
